// File: rtl/fixed_to_float_pkg.sv
// Shared definitions for the CORDIC datapath and its fixed-to-float output stage:
// the FSM state encoding, IEEE-754 single-precision field sizes and the default fixed-point format.
package fixed_to_float_pkg;

    localparam int FLOAT_W    = 32;
    localparam int EXP_W      = 8;
    localparam int MANT_W     = 23;
    localparam int EXP_BIAS   = 127;

    // Default signed fixed-point format of the CORDIC x/y results.
    localparam int DEF_INT_W  = 4;
    localparam int DEF_FRAC_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_OUT  = 2'd2
    } f2f_state_e;

    // Assemble a single-precision word from its three fields.
    function automatic logic [FLOAT_W-1:0] pack_float(
        input logic              sign,
        input logic [EXP_W-1:0]  exp,
        input logic [MANT_W-1:0] mant
    );
        pack_float = {sign, exp, mant};
    endfunction

endpackage

// File: rtl/fixed_to_float.sv
// Converts a signed fixed-point value to IEEE-754 single precision by normalising
// the magnitude one bit per enabled cycle; the conversion is exact, so no rounding is needed.
module fixed_to_float
    import fixed_to_float_pkg::*;
#(
    parameter int INT_W  = DEF_INT_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int FIX_W  = INT_W + FRAC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [FIX_W-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [FLOAT_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    // Exponent of a magnitude whose top bit is already set: that bit weighs 2^(INT_W-1).
    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(EXP_BIAS + INT_W - 1);

    f2f_state_e         state_q;
    logic               sign_q;
    logic [FIX_W-1:0]   mag_q;
    logic [EXP_W-1:0]   exp_q;
    logic [FLOAT_W-1:0] out_data_q;
    logic               out_valid_q;

    logic [FIX_W-1:0]   abs_s;
    logic [MANT_W-1:0]  mant_s;
    logic               mag_zero_s;
    logic               mag_norm_s;

    // Negating the most negative input wraps to 2^(FIX_W-1), which is the correct unsigned magnitude.
    always_comb begin
        abs_s = in_data;
        if (in_data[FIX_W-1]) begin
            abs_s = FIX_W'(~in_data + {{(FIX_W-1){1'b0}}, 1'b1});
        end else begin
            abs_s = in_data;
        end
    end

    // Fraction bits below the hidden one, left-aligned into the 23-bit mantissa field.
    always_comb begin
        mant_s = MANT_W'(mag_q[FIX_W-2:0]) << (MANT_W - (FIX_W - 1));
    end

    assign mag_zero_s = (mag_q == {FIX_W{1'b0}});
    assign mag_norm_s = mag_q[FIX_W-1];

    // Conversion FSM; every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            mag_q       <= {FIX_W{1'b0}};
            exp_q       <= {EXP_W{1'b0}};
            out_data_q  <= {FLOAT_W{1'b0}};
            out_valid_q <= 1'b0;
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_q  <= in_data[FIX_W-1];
                        mag_q   <= abs_s;
                        exp_q   <= EXP_INIT;
                        state_q <= ST_NORM;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_NORM: begin
                    if (mag_zero_s) begin
                        out_data_q  <= {FLOAT_W{1'b0}};
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else if (mag_norm_s) begin
                        out_data_q  <= pack_float(sign_q, exp_q, mant_s);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else begin
                        mag_q   <= {mag_q[FIX_W-2:0], 1'b0};
                        exp_q   <= exp_q - {{(EXP_W-1){1'b0}}, 1'b1};
                        state_q <= ST_NORM;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_OUT;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/fixed_to_float.md
FIXED_TO_FLOAT -- requirements
Module: fixed_to_float

Interface
REQ-001 Parameter INT_W, default 4: integer bits of the signed fixed-point input, sign included.
REQ-002 Parameter FRAC_W, default 20: fractional bits of the input.
REQ-003 Parameter FIX_W, default INT_W+FRAC_W: input width; SHALL be at most 24 so conversion is exact.
REQ-004 clk  in  1  clock; reset rst, synchronous, active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 en  in  1  clock enable; when low, all state and outputs SHALL hold.
REQ-007 in_data  in  FIX_W  two's-complement fixed value (CORDIC x/y result).
REQ-008 in_valid  in  1  in_data is valid.
REQ-009 in_ready  out  1  block can accept a value.
REQ-010 out_data  out  32  IEEE-754 single-precision result.
REQ-011 out_valid  out  1  out_data is valid.
REQ-012 out_ready  in  1  consumer accepts out_data.

Function
REQ-013 States: IDLE, NORM, OUT; in_ready SHALL equal (state==IDLE).
REQ-014 IDLE: on an en edge with in_valid high, capture sign=in_data[FIX_W-1], mag=|in_data| (FIX_W bits unsigned), exp=127+INT_W-1, and go to NORM.
REQ-015 NORM, mag==0: load out_data=0x00000000 (+0) and go to OUT.
REQ-016 NORM, mag MSB set: load out_data={sign, exp[7:0], mag[FIX_W-2:0] left-aligned in 23 bits, zero-padded}, and go to OUT.
REQ-017 NORM, otherwise: shift mag left by 1 and decrement exp by 1 on each en edge.
REQ-018 Latency: out_valid SHALL rise N+1 enabled edges after the accept edge, where N is the leading-zero count of mag; zero input uses N=0.
REQ-019 Maximum latency SHALL be FIX_W enabled edges.
REQ-020 OUT: out_valid is high, and out_data SHALL stay stable until an en edge with out_ready high; that edge returns the block to IDLE.
REQ-021 in_valid outside IDLE SHALL be ignored; no input buffering.
REQ-022 The most negative input (-2^(INT_W-1)) SHALL convert exactly (mag = 2^(FIX_W-1)).
REQ-023 No rounding, denormals, infinities or NaNs SHALL ever be produced; the exponent range is 127+INT_W-1 down to 127+INT_W-FIX_W.
REQ-024 A new accept SHALL be possible on the first enabled edge after the out handshake, giving one idle cycle between results.

Reset
REQ-025 On rst: state=IDLE, out_valid=0, out_data=0, and mag, exp and sign cleared; rst SHALL take priority over en.
REQ-026 rst during NORM or OUT SHALL discard the in-flight conversion; the next accept behaves as after power-up.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, FLOAT_W=32, EXP_BIAS=127 and the default INT_W/FRAC_W, also used by the CORDIC core.
REQ-028 The block SHALL be one module with no sub-modules; normalisation is iterative (one bit per cycle), not a barrel shifter.

Verification
REQ-029 in_data=0x100000 (1.0) -> out_data=0x3F800000, out_valid 4 edges after accept.
REQ-030 in_data=0xF00000 (-1.0) -> 0xBF800000; in_data=0x080000 (0.5) -> 0x3F000000.
REQ-031 in_data=0x800000 (-8.0) -> 0xC1000000 after 1 edge; in_data=0x000001 -> 0x35800000 after 24 edges.
REQ-032 in_data=0x000000 -> 0x00000000 after 1 edge; out_ready held low for 10 cycles -> out_data and out_valid stable, in_ready low, new in_valid ignored.
REQ-033 en toggled low every other cycle during 0x000001 conversion -> same result, latency counted in enabled edges only.
REQ-034 rst asserted mid-NORM -> next edge in_ready=1 and out_valid=0; following 1.0 conversion correct.
